fadd_sub_norm_round: RTL and testbench
======================================

# fadd_sub_norm_round

Back half of the single-precision FADD/FSUB datapath. It consumes the per-operand flags and the exponent-aligned 48-bit mantissas from the extract/align stage. It performs the signed magnitude add/subtract, leading-zero normalization, IEEE-754 rounding (all five RISC-V modes), special-case selection and packing. It is a 3-stage valid/ready pipeline that returns the packed 32-bit result and fflags to the FPU writeback mux.

## Interface
Parameters: none (binary32 fixed).

- clk  in  1  core clock; all state on rising edge
- reset  in  1  synchronous, active-high; clears all valid bits
- in_valid  in  1  operand bundle valid
- in_ready  out  1  bundle accepted when in_valid && in_ready
- sign1, sign2  in  1  effective signs (sign2 already includes add/sub inversion)
- exp_res  in  8  common biased exponent after alignment
- mantissa1_aligned, mantissa2_aligned  in  48  bit 47 = hidden bit, 46:24 = fraction, 23:0 = alignment extension
- NaN, inf1, inf2, res_zero  in  1  special-case flags from align stage
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others are treated as RNE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- result  out  32  packed binary32
- fflags  out  5  {NV, DZ, OF, UF, NX}; DZ is always 0

## Operation
- Eeff = max(exp_res, 1). The operand value is m * 2^(Eeff-127-47).
- S1 (add):
  - If sign1 == sign2: sum[48:0] = m1 + m2, sgn = sign1.
  - Else: sum = |m1 - m2|, and sgn is the sign of the larger operand.
  - If sum == 0 with opposite signs: sgn = (rm == RDN).
  - Latch the specials and rm.
- S2 (normalize):
  - If sum[48] = 1: shift right 1, OR the dropped bit into sticky, and set E = Eeff + 1.
  - Else: lz = leading zeros of sum[47:0], sh = min(lz, Eeff-1), shift left by sh, and set E = Eeff - sh.
  - Result n[47:0]. If n[47] = 0 after the shift, the exponent field is 0 (subnormal/zero).
- S3 (round/pack):
  - sig = n[47:24], G = n[23], R = n[22], S = |n[21:0] | sticky.
  - inc by mode:
    - RNE: G & (R | S | sig[0])
    - RTZ: 0
    - RDN: sgn & (G | R | S)
    - RUP: !sgn & (G | R | S)
    - RMM: G
  - NX = G | R | S.
  - If sig + inc == 2^24: sig = 2^23 and E += 1.
  - A subnormal whose rounding carries into bit 23 becomes exponent field 1.
  - Overflow (E >= 255): OF | NX. Result is ±inf for RNE and RMM, and for RUP (+) / RDN (-). Otherwise the result is ±0x7F7FFFFF.
  - UF = (pre-round exponent field 0) && NX.
- Special priority, highest first:
  1. NaN → 0x7FC00000, no flags (sNaN NV is merged in the FPU).
  2. inf1 && inf2 && sign1 != sign2 → 0x7FC00000, NV.
  3. inf1 → {sign1, 0x7F800000[30:0]}.
  4. inf2 → {sign2, inf}.
  5. res_zero → {rm == RDN, 31'b0}.
  6. Arithmetic result. An exact zero from same-sign zeros keeps sign1.

## Timing
- Latency is 3 cycles: a bundle accepted at edge k appears with out_valid high after edge k+3 when there is no stall.
- Throughput is 1 per cycle.
- Global stall: en = !out_valid || out_ready, and in_ready = en (combinational from out_ready).
- When en = 0, all stage registers and the outputs hold; bubbles are not collapsed.
- result and fflags are registered and stay stable while out_valid && !out_ready.
- Reset values: out_valid = 0, result = 0, fflags = 0, all stage valids = 0.
- Reset during an in-flight operation discards all bundles; out_valid = 0 on the cycle after reset and nothing flushed is ever output.
- A simultaneous accept and output handshake in the same cycle advances the whole pipe by one stage.
- in_valid low with en high inserts a bubble (stage valid = 0).

## Test plan
- 1.0 + 1.0: exp_res = 127, m1 = m2 = 48'h800000000000, signs 0, rm = RNE → result 0x40000000, fflags 0, out_valid exactly 3 cycles after accept.
- Tie rounding, 1.0 + 2^-24: exp_res = 127, m1 = 48'h800000000000, m2 = 48'h000000800000.
  - RNE → 0x3F800000, fflags 5'b00001.
  - RUP → 0x3F800001, fflags 5'b00001.
- Specials:
  - res_zero = 1 with rm = RDN → 0x80000000; with rm = RNE → 0x00000000.
  - inf1 = inf2 = 1, sign1 = 0, sign2 = 1 → 0x7FC00000, fflags 5'b10000.
- Overflow: exp_res = 254, m1 = m2 = 48'h800000000000, signs 0.
  - RNE → 0x7F800000, fflags 5'b00101.
  - RTZ → 0x7F7FFFFF, fflags 5'b00101.
- Backpressure: 5 back-to-back bundles with out_ready = 0 for cycles 3–7 → in_ready = 0 during the stall, all 5 results delivered in order, none lost or duplicated.
- Reset mid-flight: with 3 bundles in flight, assert reset for 1 cycle → out_valid = 0 the next cycle, and the first result afterwards belongs to the first post-reset bundle.

Source files
------------

// File: rtl/fadd_sub_norm_round.sv
// Binary32 FADD/FSUB back half: magnitude add, normalize, round, pack.
// Ports: valid/ready in, aligned mantissas + flags + rm; result/fflags out.
module fadd_sub_norm_round (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign1,
  input  logic        sign2,
  input  logic [7:0]  exp_res,
  input  logic [47:0] mantissa1_aligned,
  input  logic [47:0] mantissa2_aligned,
  input  logic        NaN,
  input  logic        inf1,
  input  logic        inf2,
  input  logic        res_zero,
  input  logic [2:0]  rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  typedef struct packed {
    logic       nan;
    logic       inf1;
    logic       inf2;
    logic       s1;
    logic       s2;
    logic       rz;
    logic [2:0] rm;
  } spec_t;

  typedef struct packed {
    spec_t       sp;
    logic        sgn;
    logic [48:0] sum;
    logic [7:0]  eeff;
  } s1_t;

  typedef struct packed {
    spec_t       sp;
    logic        sgn;
    logic [47:0] n;
    logic        sticky;
    logic [8:0]  efld;
  } s2_t;

  typedef struct packed {
    spec_t       sp;
    logic        sgn;
    logic [8:0]  efld;
    logic [22:0] frac;
    logic        nx;
    logic        uf;
  } s3_t;

  logic        en;
  logic        v1_q, v2_q, v3_q, ov_q;
  s1_t         s1_q, s1_d;
  s2_t         s2_q, s2_d;
  s3_t         s3_q, s3_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  ff_q, ff_d;

  assign en        = !ov_q || out_ready;
  assign in_ready  = en;
  assign out_valid = ov_q;
  assign result    = res_q;
  assign fflags    = ff_q;

  // S1: signed-magnitude add
  always_comb begin
    logic [48:0] a;
    logic [48:0] b;
    a = {1'b0, mantissa1_aligned};
    b = {1'b0, mantissa2_aligned};
    s1_d = '0;
    s1_d.sp.nan  = NaN;
    s1_d.sp.inf1 = inf1;
    s1_d.sp.inf2 = inf2;
    s1_d.sp.s1   = sign1;
    s1_d.sp.s2   = sign2;
    s1_d.sp.rz   = res_zero;
    s1_d.sp.rm   = (rm > RMM) ? RNE : rm;
    s1_d.eeff    = (exp_res == 8'd0) ? 8'd1 : exp_res;
    if (sign1 == sign2) begin
      s1_d.sum = a + b;
      s1_d.sgn = sign1;
    end else if (a > b) begin
      s1_d.sum = a - b;
      s1_d.sgn = sign1;
    end else if (b > a) begin
      s1_d.sum = b - a;
      s1_d.sgn = sign2;
    end else begin
      s1_d.sum = '0;
      s1_d.sgn = (s1_d.sp.rm == RDN);
    end
  end

  // S2: normalize; left shift capped so the exponent never drops below 1
  always_comb begin
    logic [5:0] lz;
    logic [7:0] lim;
    logic [7:0] sh;
    logic [8:0] e;
    lz = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (s1_q.sum[i]) lz = 6'(47 - i);
    end
    lim = s1_q.eeff - 8'd1;
    sh  = ({2'b0, lz} < lim) ? {2'b0, lz} : lim;
    s2_d     = '0;
    s2_d.sp  = s1_q.sp;
    s2_d.sgn = s1_q.sgn;
    if (s1_q.sum[48]) begin
      s2_d.n      = s1_q.sum[48:1];
      s2_d.sticky = s1_q.sum[0];
      e           = {1'b0, s1_q.eeff} + 9'd1;
    end else begin
      s2_d.n      = s1_q.sum[47:0] << sh;
      s2_d.sticky = 1'b0;
      e           = {1'b0, s1_q.eeff} - {1'b0, sh};
    end
    s2_d.efld = s2_d.n[47] ? e : 9'd0;
  end

  // S3: round
  always_comb begin
    logic [23:0] sig;
    logic        g, r, s, inc;
    logic [24:0] rs;
    sig = s2_q.n[47:24];
    g   = s2_q.n[23];
    r   = s2_q.n[22];
    s   = (|s2_q.n[21:0]) | s2_q.sticky;
    inc = 1'b0;
    case (s2_q.sp.rm)
      RNE:     inc = g & (r | s | sig[0]);
      RTZ:     inc = 1'b0;
      RDN:     inc = s2_q.sgn & (g | r | s);
      RUP:     inc = !s2_q.sgn & (g | r | s);
      RMM:     inc = g;
      default: inc = g & (r | s | sig[0]);
    endcase
    rs = {1'b0, sig} + {24'd0, inc};
    s3_d     = '0;
    s3_d.sp  = s2_q.sp;
    s3_d.sgn = s2_q.sgn;
    s3_d.nx  = g | r | s;
    s3_d.uf  = (s2_q.efld == 9'd0) & s3_d.nx;
    if (s2_q.efld == 9'd0) begin
      // subnormal carrying into bit 23 becomes the smallest normal
      s3_d.efld = {8'd0, rs[23]};
      s3_d.frac = rs[22:0];
    end else if (rs[24]) begin
      s3_d.efld = s2_q.efld + 9'd1;
      s3_d.frac = '0;
    end else begin
      s3_d.efld = s2_q.efld;
      s3_d.frac = rs[22:0];
    end
  end

  // Pack: overflow and special-case selection
  always_comb begin
    logic  of;
    logic  to_inf;
    spec_t sp;
    sp     = s3_q.sp;
    of     = s3_q.efld >= 9'd255;
    to_inf = (sp.rm == RNE) || (sp.rm == RMM) ||
             ((sp.rm == RUP) && !s3_q.sgn) ||
             ((sp.rm == RDN) && s3_q.sgn);
    res_d  = {s3_q.sgn, s3_q.efld[7:0], s3_q.frac};
    ff_d   = {3'b000, s3_q.uf, s3_q.nx};
    if (sp.nan) begin
      res_d = 32'h7FC0_0000;
      ff_d  = 5'b00000;
    end else if (sp.inf1 && sp.inf2 && (sp.s1 != sp.s2)) begin
      res_d = 32'h7FC0_0000;
      ff_d  = 5'b10000;
    end else if (sp.inf1) begin
      res_d = {sp.s1, 31'h7F80_0000};
      ff_d  = 5'b00000;
    end else if (sp.inf2) begin
      res_d = {sp.s2, 31'h7F80_0000};
      ff_d  = 5'b00000;
    end else if (sp.rz) begin
      res_d = {sp.rm == RDN, 31'd0};
      ff_d  = 5'b00000;
    end else if (of) begin
      res_d = to_inf ? {s3_q.sgn, 31'h7F80_0000}
                     : {s3_q.sgn, 31'h7F7F_FFFF};
      ff_d  = 5'b00101;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      ov_q  <= 1'b0;
      res_q <= '0;
      ff_q  <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      ov_q <= v3_q;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      if (v3_q) begin
        res_q <= res_d;
        ff_q  <= ff_d;
      end
    end
  end

endmodule

// File: tb/tb_fadd_sub_norm_round.sv
// Bench for fadd_sub_norm_round: vector table, pipeline corner
// sequences and a random scoreboard against an exact-arithmetic model.
module tb_fadd_sub_norm_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        sign1, sign2;
  logic [7:0]  exp_res;
  logic [47:0] mantissa1_aligned, mantissa2_aligned;
  logic        NaN, inf1, inf2, res_zero;
  logic [2:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  fflags;

  fadd_sub_norm_round dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign1(sign1), .sign2(sign2), .exp_res(exp_res),
    .mantissa1_aligned(mantissa1_aligned),
    .mantissa2_aligned(mantissa2_aligned),
    .NaN(NaN), .inf1(inf1), .inf2(inf2), .res_zero(res_zero),
    .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .fflags(fflags)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        s1, s2;
    logic [7:0]  e;
    logic [47:0] m1, m2;
    logic        nan, i1, i2, rz;
    logic [2:0]  rm;
  } bin_t;

  typedef struct {
    bin_t        b;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
  } exp_t;

  localparam logic [47:0] H = 48'h800000000000;
  localparam logic [47:0] T = 48'h000000800000;

  exp_t sb[$];
  vec_t vt[$];

  function automatic bin_t mk(input logic s1, input logic s2,
                              input logic [7:0] e,
                              input logic [47:0] m1, input logic [47:0] m2,
                              input logic [3:0] spc, input logic [2:0] r);
    bin_t b;
    b.s1 = s1; b.s2 = s2; b.e = e; b.m1 = m1; b.m2 = m2;
    b.nan = spc[3]; b.i1 = spc[2]; b.i2 = spc[1]; b.rz = spc[0];
    b.rm = r;
    return b;
  endfunction

  task automatic addv(input bin_t b, input logic [31:0] r,
                      input logic [4:0] f);
    vec_t v;
    v.b = b; v.res = r; v.fl = f;
    vt.push_back(v);
  endtask

  task automatic drive(input bin_t b);
    sign1 = b.s1; sign2 = b.s2; exp_res = b.e;
    mantissa1_aligned = b.m1; mantissa2_aligned = b.m2;
    NaN = b.nan; inf1 = b.i1; inf2 = b.i2; res_zero = b.rz;
    rm = b.rm;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // Exact value = (+-m1 +-m2) * 2^(Eeff-174), rounded to binary32.
  function automatic exp_t ref_model(input bin_t b);
    exp_t   o;
    int     rmn, eeff, s, p, k, eb;
    longint v, m, sig, rem, half;
    bit     sg, inc, nx, uf;
    o.res = 32'd0;
    o.fl  = 5'd0;
    rmn = (b.rm > 3'd4) ? 0 : int'(b.rm);
    if (b.nan) begin
      o.res = 32'h7FC00000;
      return o;
    end
    if (b.i1 && b.i2 && b.s1 != b.s2) begin
      o.res = 32'h7FC00000; o.fl = 5'b10000;
      return o;
    end
    if (b.i1) begin o.res = {b.s1, 31'h7F800000}; return o; end
    if (b.i2) begin o.res = {b.s2, 31'h7F800000}; return o; end
    if (b.rz) begin o.res = {rmn == 2, 31'd0}; return o; end
    eeff = (b.e == 0) ? 1 : int'(b.e);
    s = eeff - 174;
    v = (b.s1 ? -longint'(b.m1) : longint'(b.m1)) +
        (b.s2 ? -longint'(b.m2) : longint'(b.m2));
    m = (v < 0) ? -v : v;
    if (v < 0) sg = 1;
    else if (v > 0) sg = 0;
    else sg = (b.s1 == b.s2) ? b.s1 : (rmn == 2);
    if (m == 0) begin
      o.res = {sg, 31'd0};
      return o;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (m[i]) p = i;
    k = (p - 23 > -149 - s) ? p - 23 : -149 - s;
    if (k > 0) begin
      sig  = m >> k;
      rem  = m & ((64'd1 << k) - 1);
      half = 64'd1 << (k - 1);
    end else begin
      sig = m << (-k); rem = 0; half = 1;
    end
    case (rmn)
      0: inc = (rem > half) || (rem == half && sig[0]);
      1: inc = 0;
      2: inc = sg && rem != 0;
      3: inc = !sg && rem != 0;
      default: inc = rem >= half;
    endcase
    sig = sig + longint'(inc);
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23; k++;
    end
    nx = rem != 0;
    uf = nx && (p + s + 127 < 1);
    eb = (sig >= (64'd1 << 23)) ? k + s + 150 : 0;
    if (eb >= 255) begin
      if (rmn == 0 || rmn == 4 || (rmn == 3 && !sg) || (rmn == 2 && sg))
        o.res = {sg, 31'h7F800000};
      else
        o.res = {sg, 31'h7F7FFFFF};
      o.fl = 5'b00101;
      return o;
    end
    o.res = {sg, eb[7:0], sig[22:0]};
    o.fl  = {3'b000, uf, nx};
    return o;
  endfunction

  function automatic bin_t rnd();
    bin_t        b;
    logic [47:0] t, x;
    int          sel;
    b.s1 = 1'($urandom);
    b.s2 = 1'($urandom);
    b.rm = 3'($urandom_range(0, 7));
    sel = $urandom_range(0, 9);
    case (sel)
      0: b.e = 8'd0;
      1: b.e = 8'($urandom_range(1, 6));
      2: b.e = 8'($urandom_range(248, 254));
      default: b.e = 8'($urandom_range(1, 254));
    endcase
    b.m1 = {1'b1, 23'($urandom), 24'd0};
    if (b.e == 0 && $urandom_range(0, 1) == 1) b.m1[47] = 1'b0;
    t = {1'b1, 23'($urandom), 24'd0};
    b.m2 = t >> $urandom_range(0, 30);
    if ($urandom_range(0, 5) == 0) begin
      x = 48'($urandom_range(0, 255));
      b.m2 = b.m1 ^ (x << $urandom_range(0, 40));
    end
    if ($urandom_range(0, 1) == 1) begin
      t = b.m1; b.m1 = b.m2; b.m2 = t;
    end
    b.nan = 0; b.i1 = 0; b.i2 = 0; b.rz = 0;
    sel = $urandom_range(0, 31);
    if (sel == 0) b.nan = 1;
    if (sel == 1) b.i1 = 1;
    if (sel == 2) b.i2 = 1;
    if (sel == 3) begin b.i1 = 1; b.i2 = 1; end
    if (sel == 4) b.rz = 1;
    return b;
  endfunction

  task automatic apply_vec(input int idx, input vec_t v);
    bit got;
    got = 0;
    @(negedge clk);
    drive(v.b); in_valid = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    for (int c = 0; c < 8 && !got; c++) begin
      if (out_valid) begin
        check($sformatf("vec%0d_res", idx), result, v.res);
        check($sformatf("vec%0d_flg", idx), 32'(fflags), 32'(v.fl));
        got = 1;
      end else @(negedge clk);
    end
    if (!got) check($sformatf("vec%0d_timeout", idx), 32'd0, 32'd1);
  endtask

  initial begin
    bin_t bp[5];
    exp_t bpe[5];
    bin_t rb[3];
    bin_t nb;
    exp_t ne, e;
    bin_t cb;
    int   sent, got, extra;
    bit   seen;

    reset = 1; in_valid = 0; out_ready = 1;
    drive(mk(0, 0, 8'd0, 48'd0, 48'd0, 4'd0, 3'd0));

    addv(mk(0, 0, 127, H, H, 4'b0000, 0), 32'h40000000, 5'b00000);
    addv(mk(0, 0, 127, H, T, 4'b0000, 0), 32'h3F800000, 5'b00001);
    addv(mk(0, 0, 127, H, T, 4'b0000, 3), 32'h3F800001, 5'b00001);
    addv(mk(0, 0, 127, H, T, 4'b0000, 4), 32'h3F800001, 5'b00001);
    addv(mk(0, 0, 127, H, T, 4'b0000, 2), 32'h3F800000, 5'b00001);
    addv(mk(0, 0, 127, H, T, 4'b0000, 5), 32'h3F800000, 5'b00001);
    addv(mk(0, 0, 127, H, H, 4'b0001, 2), 32'h80000000, 5'b00000);
    addv(mk(0, 0, 127, H, H, 4'b0001, 0), 32'h00000000, 5'b00000);
    addv(mk(0, 1, 255, 0, 0, 4'b0110, 0), 32'h7FC00000, 5'b10000);
    addv(mk(0, 1, 255, 0, 0, 4'b1110, 0), 32'h7FC00000, 5'b00000);
    addv(mk(1, 0, 255, 0, 0, 4'b0100, 0), 32'hFF800000, 5'b00000);
    addv(mk(0, 1, 255, 0, 0, 4'b0010, 0), 32'hFF800000, 5'b00000);
    addv(mk(0, 0, 254, H, H, 4'b0000, 0), 32'h7F800000, 5'b00101);
    addv(mk(0, 0, 254, H, H, 4'b0000, 1), 32'h7F7FFFFF, 5'b00101);
    addv(mk(1, 1, 254, H, H, 4'b0000, 3), 32'hFF7FFFFF, 5'b00101);
    addv(mk(0, 1, 127, H, H, 4'b0000, 2), 32'h80000000, 5'b00000);
    addv(mk(0, 1, 127, H, H, 4'b0000, 0), 32'h00000000, 5'b00000);
    addv(mk(0, 0, 0, 48'h000001000000, 0, 4'b0000, 0),
         32'h00000001, 5'b00000);
    addv(mk(0, 0, 0, 48'h7FFFFF800000, 0, 4'b0000, 0),
         32'h00800000, 5'b00011);
    addv(mk(0, 1, 127, 48'hC00000000000, H, 4'b0000, 0),
         32'h3F000000, 5'b00000);
    addv(mk(0, 0, 1, 48'h000000C00000, 0, 4'b0000, 0),
         32'h00000001, 5'b00011);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_flg", 32'(fflags), 32'd0);
    check("rst_inready", 32'(in_ready), 32'd1);
    reset = 0;

    // exact three-cycle latency
    @(negedge clk);
    drive(vt[0].b); in_valid = 1; out_ready = 1;
    #1 check("lat_inready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 0;
    check("lat_k0", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_k1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_k2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_k3", 32'(out_valid), 32'd1);
    check("lat_res", result, 32'h40000000);

    foreach (vt[i]) apply_vec(i, vt[i]);

    // backpressure: 5 back-to-back bundles, stall cycles 3..7
    for (int i = 0; i < 5; i++) begin
      bp[i] = mk(0, 0, 8'(127 + i), H, T << i, 4'b0000, 3'd3);
      bpe[i] = ref_model(bp[i]);
    end
    @(negedge clk);
    sent = 0; got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      if (sent < 5) begin
        drive(bp[sent]); in_valid = 1;
      end else in_valid = 0;
      #1;
      if (out_valid && !out_ready) begin
        check($sformatf("bp_inready_c%0d", c), 32'(in_ready), 32'd0);
        check($sformatf("bp_hold_c%0d", c), result, bpe[got].res);
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_res%0d", got), result, bpe[got].res);
        check($sformatf("bp_flg%0d", got), 32'(fflags), 32'(bpe[got].fl));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    check("bp_count", 32'(got), 32'd5);
    extra = 0;
    repeat (6) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    check("bp_nodup", 32'(extra), 32'd0);

    // reset with three bundles in flight
    for (int i = 0; i < 3; i++)
      rb[i] = mk(0, 0, 8'(100 + i), H, H, 4'b0000, 3'd0);
    nb = mk(1, 1, 8'd130, H, T, 4'b0000, 3'd0);
    ne = ref_model(nb);
    for (int i = 0; i < 3; i++) begin
      drive(rb[i]); in_valid = 1;
      @(negedge clk);
    end
    in_valid = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    check("mrst_ov", 32'(out_valid), 32'd0);
    check("mrst_res", result, 32'd0);
    drive(nb); in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (out_valid) begin
        check("mrst_first_res", result, ne.res);
        check("mrst_first_flg", 32'(fflags), 32'(ne.fl));
        seen = 1;
      end else @(negedge clk);
    end
    if (!seen) check("mrst_timeout", 32'd0, 32'd1);
    @(negedge clk);

    // random traffic with scoreboard
    for (int c = 0; c < 4000; c++) begin
      cb = rnd();
      drive(cb);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check($sformatf("rnd_extra_c%0d", c), 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check($sformatf("rnd_res_c%0d", c), result, e.res);
          check($sformatf("rnd_flg_c%0d", c), 32'(fflags), 32'(e.fl));
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_model(cb));
      @(negedge clk);
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (out_valid) begin
        e = sb.pop_front();
        check("drain_res", result, e.res);
        check("drain_flg", 32'(fflags), 32'(e.fl));
      end
      @(negedge clk);
    end
    check("drain_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
